// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divide execution unit and the
// divide reservation station that feeds it.
//   DIV_XLEN / DIV_ROB_IDX_W : default operand width and ROB tag width
//   div_op_e                 : divide/remainder opcode encoding
//   div_state_e              : execution unit sequencing states
//   div_req_t                : one issued divide request (op, operands, tag)
package div_pkg;

  localparam int DIV_XLEN      = 32;
  localparam int DIV_ROB_IDX_W = 5;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    div_op_e                    op;
    logic [DIV_XLEN-1:0]        rs1;
    logic [DIV_XLEN-1:0]        rs2;
    logic [DIV_ROB_IDX_W-1:0]   rob_idx;
  } div_req_t;

  // Signed variants need magnitude conversion and a sign fix-up at the end.
  function automatic logic op_is_signed(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   acc_in  : {partial remainder, remaining dividend/quotient bits}
//   divisor : divisor magnitude
//   acc_out : accumulator after shift, trial subtract and quotient bit insert
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   divisor,
  output logic [2*XLEN-1:0] acc_out
);

  // The shifted partial remainder can reach 2*divisor-1, so keep the bit that
  // falls off the top of the remainder half; dropping it breaks divisors with
  // the MSB set.
  logic [XLEN:0]   partial;
  logic [XLEN-1:0] diff;
  logic            fits;

  assign partial = acc_in[2*XLEN-1:XLEN-1];
  assign fits    = (partial >= {1'b0, divisor});
  // When it fits the true difference is below the divisor, so XLEN bits suffice.
  assign diff    = partial[XLEN-1:0] - divisor;

  assign acc_out = fits ? {diff, acc_in[XLEN-2:0], 1'b1}
                        : {partial[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};

endmodule

// File: rtl/div_exec_unit.sv
// div_exec_unit: iterative radix-2 divide/remainder unit between the divide
// reservation station and the ROB fill interface. One op in flight at a time.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : issue handshake; in_op, in_rs1, in_rs2, in_rob_idx
//   flush             : kills any in-flight op, blocks a same-cycle issue
//   out_valid/out_ready : result handshake; out_data, out_rob_idx
//   busy              : an op has been accepted and not yet drained
module div_exec_unit
  import div_pkg::*;
#(
  parameter int XLEN      = DIV_XLEN,
  parameter int ROB_IDX_W = DIV_ROB_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [XLEN-1:0]      in_rs2,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_data,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic                 busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  div_state_e             state;
  div_op_e                op_q;
  logic [XLEN-1:0]        divisor_q;
  logic [2*XLEN-1:0]      acc_q;
  logic                   quo_neg_q;
  logic                   rem_neg_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [XLEN-1:0]        out_data_q;
  logic [ROB_IDX_W-1:0]   out_rob_idx_q;

  logic                   accept;
  logic                   in_signed;
  logic                   rs1_neg;
  logic                   rs2_neg;
  logic [XLEN-1:0]        rs1_abs;
  logic [XLEN-1:0]        rs2_abs;
  logic                   div_by_zero;
  logic                   overflow;
  logic [XLEN-1:0]        special_result;
  logic [2*XLEN-1:0]      step_acc;
  logic [XLEN-1:0]        quo_raw;
  logic [XLEN-1:0]        rem_raw;
  logic [XLEN-1:0]        final_result;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_data    = out_data_q;
  assign out_rob_idx = out_rob_idx_q;

  assign accept    = in_valid && in_ready && !flush;
  assign in_signed = op_is_signed(div_op_e'(in_op));
  assign rs1_neg   = in_signed && in_rs1[XLEN-1];
  assign rs2_neg   = in_signed && in_rs2[XLEN-1];
  assign rs1_abs   = rs1_neg ? -in_rs1 : in_rs1;
  assign rs2_abs   = rs2_neg ? -in_rs2 : in_rs2;

  // Cases the shift-subtract loop cannot produce directly bypass CALC.
  assign div_by_zero = (in_rs2 == '0);
  assign overflow    = in_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (in_rs2 == '1);
  // in_op[1] selects the remainder flavour of the op.
  assign special_result = div_by_zero ? (in_op[1] ? in_rs1 : '1)
                                      : (in_op[1] ? '0 : in_rs1);

  div_step #(.XLEN(XLEN)) u_step (
    .acc_in  (acc_q),
    .divisor (divisor_q),
    .acc_out (step_acc)
  );

  // Sign fix-up on the result of the final step, folded into the DONE entry.
  assign quo_raw      = step_acc[XLEN-1:0];
  assign rem_raw      = step_acc[2*XLEN-1:XLEN];
  assign final_result = ((op_q == REM) || (op_q == REMU))
                        ? (rem_neg_q ? -rem_raw : rem_raw)
                        : (quo_neg_q ? -quo_raw : quo_raw);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= DIVU;
      divisor_q     <= '0;
      acc_q         <= '0;
      quo_neg_q     <= 1'b0;
      rem_neg_q     <= 1'b0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_rob_idx_q <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q          <= div_op_e'(in_op);
            out_rob_idx_q <= in_rob_idx;
            divisor_q     <= rs2_abs;
            acc_q         <= {{XLEN{1'b0}}, rs1_abs};
            quo_neg_q     <= rs1_neg ^ rs2_neg;
            rem_neg_q     <= rs1_neg;
            cnt_q         <= '0;
            if (div_by_zero || overflow) begin
              out_data_q <= special_result;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            out_data_q <= final_result;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_exec_unit.md
Name: div_exec_unit

Overview:
Iterative radix-2 integer divide execution unit fed directly by the divide reservation station. It accepts one ready-operand divide/remainder op at a time, computes it over a fixed number of cycles, and presents the result with its ROB tag to the ROB fill interface. It reports busy status back to the reservation station so no second op issues while one is in flight.

Parameters:
XLEN, 32, operand and result width
ROB_IDX_W, 5, ROB tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  reservation station issues an op
in_ready  out  1  unit can accept an op this cycle
in_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
in_rs1  in  XLEN  dividend
in_rs2  in  XLEN  divisor
in_rob_idx  in  ROB_IDX_W  destination ROB tag
flush  in  1  pipeline flush; kill in-flight op
out_valid  out  1  result valid toward ROB fill
out_ready  in  1  ROB fill accepts result
out_data  out  XLEN  quotient or remainder
out_rob_idx  out  ROB_IDX_W  tag of the result
busy  out  1  op accepted and not yet drained

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; busy=0; out_data=0; out_rob_idx=0.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE). busy = (state!=IDLE). Both are combinational from state.
- Accept happens when in_valid && in_ready && !flush. On accept, latch op, tag, |rs1|, |rs2| (signed ops only), and the sign flags. Clear the iteration counter.
- Special cases are detected at accept and skip CALC; the next state is DONE (out_valid at t+1):
  - divisor==0: quotient=all ones, remainder=rs1 (raw, unsigned or signed alike).
  - signed overflow (rs1==1<<(XLEN-1), rs2==all ones, op DIV/REM): quotient=rs1, remainder=0.
- CALC: one restoring shift-subtract step per cycle over a 2*XLEN partial-remainder/quotient register. Exactly XLEN steps. Counter is $clog2(XLEN)+1 bits and moves to DONE after step XLEN-1.
- Normal latency: accept at cycle t gives out_valid=1 at t+XLEN+1 (t+33 for XLEN=32).
- Sign fix-up is applied when entering DONE:
  - quotient is negated if the signs of rs1 and rs2 differ (signed ops);
  - remainder takes the sign of rs1 (signed ops);
  - unsigned ops use raw values.
- DONE: out_valid=1; out_data and out_rob_idx stay stable until out_ready. On out_valid && out_ready, go to IDLE next cycle. There is no same-cycle re-accept; in_ready rises the cycle after the handshake.
- flush (any state) has priority over accept and handshake. Next cycle: IDLE, out_valid=0, nothing emitted. A flush asserted in the same cycle as in_valid means the op is not accepted.
- rst mid-operation behaves identically to flush and also zeroes out_data and out_rob_idx.
- Inputs other than flush are ignored outside IDLE.

Decomposition:
- Shared package div_pkg:
  - enum div_op_e {DIV, DIVU, REM, REMU};
  - XLEN and ROB_IDX_W defaults;
  - struct div_req_t {op, rs1, rs2, rob_idx}, reused by the reservation station's execute-instr port.
- Sub-module div_step: combinational single restoring iteration (shift, trial subtract, quotient bit). It is instantiated once inside div_exec_unit.

Test Plan:
- DIVU rs1=100, rs2=7, tag=3, accepted at t -> out_valid at t+33, out_data=14, out_rob_idx=3; REMU same operands -> 2.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> out_data=0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
- DIV rs1=5, rs2=0 -> out_valid at t+1, out_data=0xFFFFFFFF; REM 5/0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> out_data=0x80000000 at t+1; REM same operands -> 0.
- out_ready held 0 for 10 cycles after out_valid -> out_data, out_rob_idx and out_valid stable throughout; in_valid pulses during that window are not accepted; in_ready=1 the cycle after the handshake.
- flush at t+10 during CALC, with in_valid asserted the same cycle -> no out_valid ever for either op; in_ready=1, busy=0 at t+11; a new op accepted at t+11 completes at t+44.
